shift_frame_driver: RTL
=======================

SHIFT_FRAME_DRIVER -- requirements
Module: shift_frame_driver

Interface
REQ-001 Parameter WIDTH, default 4: bits per frame, legal range 2..16.
REQ-002 Parameter GAP, default 1: idle cycles inserted after each frame, legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  parallel word offered.
REQ-006 in_data  input  WIDTH  word to serialise.
REQ-007 in_msb_first  input  1  1 = transmit MSB first, 0 = LSB first.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 serial_out  output  1  serial bit for the downstream shift register serial input.
REQ-010 shift_left_out  output  1  direction for the downstream shift register: 1 = left, 0 = right.
REQ-011 shift_en  output  1  serial_out is valid this cycle and downstream shall shift.
REQ-012 frame_done  output  1  one-cycle pulse: downstream register now holds the complete word.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 frame_count  output  8  number of completed frames, modulo 256.

Function
REQ-015 States: IDLE, SHIFT, DONE, GAP. All outputs are registered.
REQ-016 IDLE: in_ready=1, shift_en=0, busy=0.
REQ-017 Accept occurs on a rising edge where in_valid=1 and in_ready=1.
- On accept, in_data and in_msb_first are latched.
- The state moves to SHIFT with bit index 0.
REQ-018 In_valid in any state other than IDLE is ignored; no data is latched.
REQ-019 SHIFT lasts exactly WIDTH cycles with shift_en=1 and in_ready=0.
REQ-020 MSB-first frames:
- serial_out in SHIFT cycle k (k=0..WIDTH-1) = latched bit WIDTH-1-k.
- shift_left_out=1.
REQ-021 LSB-first frames:
- serial_out in SHIFT cycle k = latched bit k.
- shift_left_out=0.
REQ-022 shift_left_out holds its value from the first SHIFT cycle through DONE.
REQ-023 Bit ordering: after WIDTH enabled shifts, a downstream 4-bit bidirectional register (left shift: serial bit into bit 0; right shift: serial bit into bit 3) holds exactly the latched word.
REQ-024 After the last SHIFT cycle, DONE lasts one cycle:
- frame_done=1, shift_en=0.
- frame_count increments by 1, wrapping 255->0.
REQ-025 State after DONE:
- GAP>0: GAP cycles with busy=1, in_ready=0, then IDLE.
- GAP=0: IDLE directly.
REQ-026 Latency: word accepted at edge T gives the first bit in cycle T+1, the last bit in cycle T+WIDTH, and frame_done in cycle T+WIDTH+1.
REQ-027 Back-to-back throughput: one word per WIDTH+1+GAP+1 cycles.
REQ-028 serial_out is 0 whenever shift_en=0.
REQ-029 Changes to in_data or in_msb_first after accept have no effect on the frame in flight.

Reset
REQ-030 While rst=1, independent of clk:
- state=IDLE.
- serial_out=0, shift_left_out=0, shift_en=0, frame_done=0, busy=0, frame_count=0.
- in_ready=0.
REQ-031 in_ready rises to 1 on the first rising edge after rst deasserts.
REQ-032 Reset mid-frame discards the frame: no frame_done, no frame_count increment, no further shift_en pulses.

Verification
REQ-033 MSB-first (WIDTH=4, GAP=1): in_data=4'b1011 accepted at T.
- serial_out=1,0,1,1 in T+1..T+4 with shift_en=1 and shift_left_out=1.
- frame_done in T+5; downstream register=4'b1011; frame_count=1.
REQ-034 LSB-first: in_data=4'b1011, in_msb_first=0.
- serial_out=1,1,0,1 with shift_left_out=0.
- downstream register=4'b1011 at frame_done.
REQ-035 Back-to-back: in_valid held at 1 with words 4'hA then 4'h5.
- Second accept occurs exactly 7 cycles after the first (4 SHIFT + 1 DONE + 1 GAP + 1 IDLE).
- Both words are received intact.
REQ-036 Reset mid-frame: rst asserted during SHIFT cycle 2.
- All outputs go to reset values immediately; no frame_done.
- frame_count unchanged at 0; a next frame after reset transmits correctly.
REQ-037 Wrap: 256 frames completed -> frame_count reads 0 after the 256th frame_done.
REQ-038 GAP=0 build: DONE is followed directly by IDLE, and back-to-back spacing is 6 cycles.

Source files
------------

// File: rtl/shift_frame_driver.sv
// shift_frame_driver: serialises a WIDTH-bit word MSB- or LSB-first into a
// downstream bidirectional shift register, then idles for GAP cycles.
module shift_frame_driver #(
   parameter int WIDTH = 4,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_msb_first,
   output logic             in_ready,
   output logic             serial_out,
   output logic             shift_left_out,
   output logic             shift_en,
   output logic             frame_done,
   output logic             busy,
   output logic [7:0]       frame_count
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam int GAP_W = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE,
      S_GAP
   } state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [WIDTH-1:0] r_shreg;
   logic             r_ready;
   logic             r_serial;
   logic             r_left;
   logic             r_shift_en;
   logic             r_done;
   logic             r_busy;
   logic [7:0]       r_count;

   logic             w_accept;
   logic [WIDTH-1:0] w_shreg_next;
   logic             w_last_bit;
   logic             w_gap_end;

   // The bit leaving the word next sits at the end facing the shift direction.
   function automatic logic lead_bit(input logic [WIDTH-1:0] word, input logic msb_first);
      lead_bit = msb_first ? word[WIDTH-1] : word[0];
   endfunction

   assign w_accept     = (r_state == S_IDLE) && r_ready && in_valid;
   assign w_shreg_next = r_left ? (r_shreg << 1) : (r_shreg >> 1);
   assign w_last_bit   = (r_idx == IDX_W'(WIDTH - 1));
   assign w_gap_end    = (r_gap_cnt == GAP_W'(GAP - 1));

   // Word store: loaded on accept, consumed one bit per SHIFT cycle.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_shreg <= in_data;
      end else if (r_state == S_SHIFT) begin
         r_shreg <= w_shreg_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_gap_cnt  <= '0;
         r_ready    <= 1'b0;
         r_serial   <= 1'b0;
         r_left     <= 1'b0;
         r_shift_en <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
         r_count    <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state    <= S_SHIFT;
                  r_idx      <= '0;
                  r_ready    <= 1'b0;
                  r_busy     <= 1'b1;
                  r_shift_en <= 1'b1;
                  r_left     <= in_msb_first;
                  r_serial   <= lead_bit(in_data, in_msb_first);
               end else begin
                  // Readiness comes one edge after reset release.
                  r_ready <= 1'b1;
               end
            end
            S_SHIFT: begin
               if (w_last_bit) begin
                  r_state    <= S_DONE;
                  r_shift_en <= 1'b0;
                  r_serial   <= 1'b0;
                  r_done     <= 1'b1;
                  r_count    <= r_count + 8'd1;
               end else begin
                  r_idx    <= r_idx + IDX_W'(1);
                  r_serial <= lead_bit(w_shreg_next, r_left);
               end
            end
            S_DONE: begin
               r_done <= 1'b0;
               if (GAP == 0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end else begin
                  r_state   <= S_GAP;
                  r_gap_cnt <= '0;
               end
            end
            S_GAP: begin
               if (w_gap_end) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end else begin
                  r_gap_cnt <= r_gap_cnt + GAP_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready       = r_ready;
   assign serial_out     = r_serial;
   assign shift_left_out = r_left;
   assign shift_en       = r_shift_en;
   assign frame_done     = r_done;
   assign busy           = r_busy;
   assign frame_count    = r_count;

endmodule
